// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets and the axis-total helper used by the raster generator.
// Pure constants; no logic, no latency, no flow control.
package vga_timing_pkg;

  // 640x480@60
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  // 800x600@60
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FRONT  = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BACK   = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FRONT  = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BACK   = 23;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, end-of-axis flag and sync-window decode.
// Count updates on enabled edges; o_Wrap/o_In_Win are 0-cycle decodes; i_En low holds state.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int COUNT_W = 10,
  parameter int TOTAL   = 800,
  parameter int WIN_LO  = 656,
  parameter int WIN_HI  = 751
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_En,
  output logic [COUNT_W-1:0] o_Count,
  output logic               o_Wrap,
  output logic               o_In_Win
);

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] LO   = COUNT_W'(WIN_LO);
  localparam logic [COUNT_W-1:0] HI   = COUNT_W'(WIN_HI);

  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      count_q <= '0;
    end else if (i_En) begin
      count_q <= o_Wrap ? '0 : count_q + ONE;
    end
  end

  assign o_Count  = count_q;
  assign o_Wrap   = (count_q == LAST);
  assign o_In_Win = (count_q >= LO) && (count_q <= HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: syncs, data-enable, line/frame strobes and counts.
// Combinational decode of the counters (0 cycles); with VGA_TIMING_REG_OUT_EN all
// outputs are registered (+1 enabled pixel). i_Pix_En low freezes everything.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int   H_FRONT   = VGA640_H_FRONT,
  parameter int   H_SYNC    = VGA640_H_SYNC,
  parameter int   H_BACK    = VGA640_H_BACK,
  parameter int   V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int   V_FRONT   = VGA640_V_FRONT,
  parameter int   V_SYNC    = VGA640_V_SYNC,
  parameter int   V_BACK    = VGA640_V_BACK,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   COUNT_W   = 10
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Pix_En,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_Active,
  output logic               o_Line_Start,
  output logic               o_Frame_Start,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count
);

  localparam int H_TOTAL   = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL   = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int H_SYNC_LO = H_ACTIVE + H_FRONT;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC - 1;
  localparam int V_SYNC_LO = V_ACTIVE + V_FRONT;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC - 1;

  localparam logic [COUNT_W-1:0] H_ACT_C = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT_C = COUNT_W'(V_ACTIVE);

  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_timing_gen: sync width must be at least one");
  end
  if (H_TOTAL > (1 << COUNT_W) || V_TOTAL > (1 << COUNT_W)) begin : g_bad_width
    $error("vga_timing_gen: COUNT_W too narrow for the line or frame total");
  end

  logic [COUNT_W-1:0] col, row;
  logic               col_wrap, row_wrap_unused;
  logic               h_in_win, v_in_win;

  vga_axis_counter #(
    .COUNT_W (COUNT_W),
    .TOTAL   (H_TOTAL),
    .WIN_LO  (H_SYNC_LO),
    .WIN_HI  (H_SYNC_HI)
  ) u_col (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_En     (i_Pix_En),
    .o_Count  (col),
    .o_Wrap   (col_wrap),
    .o_In_Win (h_in_win)
  );

  // Row advances only on the edge that wraps the column, so vsync moves at line boundaries.
  vga_axis_counter #(
    .COUNT_W (COUNT_W),
    .TOTAL   (V_TOTAL),
    .WIN_LO  (V_SYNC_LO),
    .WIN_HI  (V_SYNC_HI)
  ) u_row (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_En     (i_Pix_En & col_wrap),
    .o_Count  (row),
    .o_Wrap   (row_wrap_unused),
    .o_In_Win (v_in_win)
  );

  logic hs_c, vs_c, act_c, ls_c, fs_c;

  assign hs_c  = h_in_win ? HSYNC_POL : ~HSYNC_POL;
  assign vs_c  = v_in_win ? VSYNC_POL : ~VSYNC_POL;
  assign act_c = (col < H_ACT_C) && (row < V_ACT_C);
  assign ls_c  = (col == '0);
  assign fs_c  = ls_c && (row == '0);

`ifdef VGA_TIMING_REG_OUT_EN
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_HSync       <= ~HSYNC_POL;
      o_VSync       <= ~VSYNC_POL;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
    end else if (i_Pix_En) begin
      o_HSync       <= hs_c;
      o_VSync       <= vs_c;
      o_Active      <= act_c;
      o_Line_Start  <= ls_c;
      o_Frame_Start <= fs_c;
      o_Col_Count   <= col;
      o_Row_Count   <= row;
    end
  end
`else
  assign o_HSync       = hs_c;
  assign o_VSync       = vs_c;
  assign o_Active      = act_c;
  assign o_Line_Start  = ls_c;
  assign o_Frame_Start = fs_c;
  assign o_Col_Count   = col;
  assign o_Row_Count   = row;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640x480 defaults, 800x600 with positive syncs, and a tiny raster for frame wrap.
module tb_vga_timing_gen;

  logic i_Clk = 1'b0;
  logic i_Reset;
  logic i_Pix_En;

  always #5 i_Clk = ~i_Clk;

  logic        d1_hs, d1_vs, d1_act, d1_ls, d1_fs;
  logic [9:0]  d1_col, d1_row;
  logic        d2_hs, d2_vs, d2_act, d2_ls, d2_fs;
  logic [10:0] d2_col, d2_row;
  logic        d3_hs, d3_vs, d3_act, d3_ls, d3_fs;
  logic [3:0]  d3_col, d3_row;

  vga_timing_gen u_dut1 (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .o_HSync(d1_hs), .o_VSync(d1_vs), .o_Active(d1_act),
    .o_Line_Start(d1_ls), .o_Frame_Start(d1_fs),
    .o_Col_Count(d1_col), .o_Row_Count(d1_row)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_ACTIVE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COUNT_W(11)
  ) u_dut2 (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .o_HSync(d2_hs), .o_VSync(d2_vs), .o_Active(d2_act),
    .o_Line_Start(d2_ls), .o_Frame_Start(d2_fs),
    .o_Col_Count(d2_col), .o_Row_Count(d2_row)
  );

  // 12 x 7 raster with zero front/back porches; hsync cols 8..10, vsync rows 5..6.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(0), .H_SYNC(3), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(0),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COUNT_W(4)
  ) u_dut3 (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Pix_En(i_Pix_En),
    .o_HSync(d3_hs), .o_VSync(d3_vs), .o_Active(d3_act),
    .o_Line_Start(d3_ls), .o_Frame_Start(d3_fs),
    .o_Col_Count(d3_col), .o_Row_Count(d3_row)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en);
    i_Pix_En = en;
    @(posedge i_Clk);
    #1;
  endtask

  typedef struct {
    int   adv;
    int   col;
    int   row;
    logic hs;
    logic vs;
    logic act;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[12];

  int h1_low, h1_first, h1_last, a1_cnt, a1_last, ls1_cnt, ls1_pos;
  int h2_high, h2_first, h2_last, v2_high;
  int d3_bad, fs3_cnt, vs3_low, a3_cnt, hs3_low, ls3_cnt;
  int mcol, mrow;
  logic ehs, evs, eact, els, efs;

  initial begin
    tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{638,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1,    640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{15,   655, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1,    656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{95,   751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1,    752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{47,   799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1,    0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1,    1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4899, 100, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset values appear without any clock edge having been seen.
    i_Reset = 1'b1;
    i_Pix_En = 1'b0;
    #3;
    chk("rst_col", int'(d1_col), 0);
    chk("rst_row", int'(d1_row), 0);
    chk("rst_hs", int'(d1_hs), 1);
    chk("rst_vs", int'(d1_vs), 1);
    chk("rst_act", int'(d1_act), 1);
    chk("rst_ls", int'(d1_ls), 1);
    chk("rst_fs", int'(d1_fs), 1);
    chk("rst_d2_hs", int'(d2_hs), 0);
    chk("rst_d2_vs", int'(d2_vs), 0);

    @(negedge i_Clk);
    i_Reset = 1'b0;

    // Free run: sample index i is the number of enabled edges since reset.
    h1_low = 0; h1_first = -1; h1_last = -1; a1_cnt = 0; a1_last = -1; ls1_cnt = 0; ls1_pos = -1;
    h2_high = 0; h2_first = -1; h2_last = -1; v2_high = 0;
    d3_bad = 0; fs3_cnt = 0; vs3_low = 0; a3_cnt = 0; hs3_low = 0; ls3_cnt = 0;
    for (int i = 0; i < 1056; i++) begin
      if (i < 800) begin
        if (!d1_hs) begin
          h1_low++;
          if (h1_first < 0) h1_first = i;
          h1_last = i;
        end
        if (d1_act) begin
          a1_cnt++;
          a1_last = i;
        end
        if (d1_ls) begin
          ls1_cnt++;
          ls1_pos = i;
        end
      end
      if (d2_hs) begin
        h2_high++;
        if (h2_first < 0) h2_first = i;
        h2_last = i;
      end
      if (d2_vs) v2_high++;
      if (i < 168) begin
        mcol = i % 12;
        mrow = (i / 12) % 7;
        ehs  = !(mcol >= 8 && mcol <= 10);
        evs  = !(mrow >= 5 && mrow <= 6);
        eact = (mcol < 8) && (mrow < 4);
        els  = (mcol == 0);
        efs  = (mcol == 0) && (mrow == 0);
        if (int'(d3_col) != mcol || int'(d3_row) != mrow || d3_hs != ehs ||
            d3_vs != evs || d3_act != eact || d3_ls != els || d3_fs != efs)
          d3_bad++;
        if (i < 84) begin
          if (d3_fs) fs3_cnt++;
          if (!d3_vs) vs3_low++;
          if (d3_act) a3_cnt++;
          if (!d3_hs) hs3_low++;
          if (d3_ls) ls3_cnt++;
        end
      end
      step(1'b1);
    end

    chk("d1_hsync_low_cycles", h1_low, 96);
    chk("d1_hsync_first_col", h1_first, 656);
    chk("d1_hsync_last_col", h1_last, 751);
    chk("d1_active_cycles", a1_cnt, 640);
    chk("d1_active_last_col", a1_last, 639);
    chk("d1_line_start_count", ls1_cnt, 1);
    chk("d1_line_start_col", ls1_pos, 0);
    chk("d1_after_1056_col", int'(d1_col), 256);
    chk("d1_after_1056_row", int'(d1_row), 1);
    chk("d2_hsync_high_cycles", h2_high, 128);
    chk("d2_hsync_first_col", h2_first, 840);
    chk("d2_hsync_last_col", h2_last, 967);
    chk("d2_vsync_high_row0", v2_high, 0);
    chk("d2_line_len_col", int'(d2_col), 0);
    chk("d2_line_len_row", int'(d2_row), 1);
    chk("d3_sample_errors", d3_bad, 0);
    chk("d3_frame_starts", fs3_cnt, 1);
    chk("d3_vsync_low_cycles", vs3_low, 24);
    chk("d3_active_cycles", a3_cnt, 32);
    chk("d3_hsync_low_cycles", hs3_low, 21);
    chk("d3_line_starts", ls3_cnt, 7);

    // Fresh reset, then a stall sitting on the strobes.
    i_Reset = 1'b1;
    #2;
    i_Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0);
      chk("stall0_col", int'(d1_col), 0);
      chk("stall0_ls", int'(d1_ls), 1);
      chk("stall0_fs", int'(d1_fs), 1);
    end

    for (int k = 0; k < 12; k++) begin
      repeat (tbl[k].adv) step(1'b1);
      chk($sformatf("vec%0d_col", k), int'(d1_col), tbl[k].col);
      chk($sformatf("vec%0d_row", k), int'(d1_row), tbl[k].row);
      chk($sformatf("vec%0d_hs", k), int'(d1_hs), int'(tbl[k].hs));
      chk($sformatf("vec%0d_vs", k), int'(d1_vs), int'(tbl[k].vs));
      chk($sformatf("vec%0d_act", k), int'(d1_act), int'(tbl[k].act));
      chk($sformatf("vec%0d_ls", k), int'(d1_ls), int'(tbl[k].ls));
      chk($sformatf("vec%0d_fs", k), int'(d1_fs), int'(tbl[k].fs));
    end

    // Hold at (100,7) for five cycles, then one enabled edge.
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      chk("hold_col", int'(d1_col), 100);
      chk("hold_row", int'(d1_row), 7);
      chk("hold_hs", int'(d1_hs), 1);
      chk("hold_act", int'(d1_act), 1);
      chk("hold_ls", int'(d1_ls), 0);
    end
    step(1'b1);
    chk("resume_col", int'(d1_col), 101);
    chk("resume_row", int'(d1_row), 7);

    // Asynchronous reset between edges at (400,7).
    repeat (299) step(1'b1);
    chk("pre_rst_col", int'(d1_col), 400);
    #3;
    i_Reset = 1'b1;
    #1;
    chk("mid_rst_col", int'(d1_col), 0);
    chk("mid_rst_row", int'(d1_row), 0);
    chk("mid_rst_fs", int'(d1_fs), 1);
    chk("mid_rst_act", int'(d1_act), 1);
    chk("mid_rst_hs", int'(d1_hs), 1);
    chk("mid_rst_d2_col", int'(d2_col), 0);
    #1;
    i_Reset = 1'b0;
    #1;
    chk("post_rst_col", int'(d1_col), 0);
    chk("post_rst_fs", int'(d1_fs), 1);
    step(1'b1);
    chk("post_rst_edge_col", int'(d1_col), 1);
    chk("post_rst_edge_row", int'(d1_row), 0);
    chk("post_rst_edge_fs", int'(d1_fs), 0);
    repeat (799) step(1'b1);
    chk("post_rst_line_col", int'(d1_col), 0);
    chk("post_rst_line_row", int'(d1_row), 1);
    chk("post_rst_line_ls", int'(d1_ls), 1);
    chk("post_rst_line_fs", int'(d1_fs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 sync counter. It adds independent front-porch, sync and back-porch parameters, programmable sync polarity, a pixel clock-enable for running from a faster system clock, and a data-enable plus line/frame start strobes. It sits between the board clock and the pixel-pattern and framebuffer readers, which use its counters and strobes to fetch and gate pixel data.

## Interface
- H_ACTIVE, 640, visible columns
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible rows
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines
- HSYNC_POL, 0, asserted level of o_HSync
- VSYNC_POL, 0, asserted level of o_VSync
- COUNT_W, 10, counter width; must satisfy H_TOTAL ≤ 2^COUNT_W and V_TOTAL ≤ 2^COUNT_W
- i_Clk  in  1  system clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Pix_En  in  1  pixel tick; counters advance only on edges where it is 1
- o_HSync  out  1  horizontal sync at the configured polarity
- o_VSync  out  1  vertical sync at the configured polarity
- o_Active  out  1  high while col < H_ACTIVE and row < V_ACTIVE
- o_Line_Start  out  1  high while col == 0
- o_Frame_Start  out  1  high while col == 0 and row == 0
- o_Col_Count  out  COUNT_W  current column
- o_Row_Count  out  COUNT_W  current row

## Operation
- Derived totals: H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK; V_TOTAL is the vertical equivalent.
- On each i_Clk edge with i_Pix_En = 1:
  - col increments.
  - When col == H_TOTAL-1, col wraps to 0 and row increments.
  - When row == V_TOTAL-1 at that same edge, row also wraps to 0.
- With i_Pix_En = 0, all state and outputs hold.
- Horizontal sync window: col in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - o_HSync = HSYNC_POL inside the window, ~HSYNC_POL outside it.
- Vertical sync window: row in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], with the same polarity rule using VSYNC_POL.
- Vertical sync changes only at line boundaries, because row changes only at col wrap.
- Zero-width porches are legal. A zero sync width is illegal and is rejected by an elaboration-time check, as is a COUNT_W overflow.
- All arithmetic is unsigned at COUNT_W bits. Window bounds are computed as parameters, never in runtime logic.

## Timing
- Reset (asynchronous):
  - Counters go to 0 immediately, with no clock edge required.
  - Default build outputs during reset: o_Active = 1, o_Line_Start = 1, o_Frame_Start = 1, syncs at their inactive levels, counts 0.
- Default build: all outputs are combinational decodes of the counter registers, giving 0 cycles of latency from the count.
- One line takes H_TOTAL enabled cycles; one frame takes H_TOTAL*V_TOTAL enabled cycles.
- o_Line_Start is one enabled pixel wide per line. o_Frame_Start is one enabled pixel wide per frame.
- If i_Pix_En is low, each strobe stays high for the whole stall.
- Reset asserted mid-frame aborts the frame. After release, counting resumes from (0,0) on the first enabled edge.

## Configuration
- VGA_TIMING_REG_OUT_EN:
  - Defined: o_HSync, o_VSync, o_Active, the two strobes and both counts are registered, loaded on enabled edges.
  - All outputs then lag the internal counters by exactly one enabled pixel and remain mutually aligned.
  - Registered outputs reset to: syncs inactive, o_Active = 0, strobes 0, counts 0.
  - Undefined: outputs are combinational decodes, as described under Timing.

## Structure
- Package vga_timing_pkg holds:
  - localparam sets for 640x480@60 (the defaults) and 800x600@60 (40/128/88, 1/4/23).
  - A function computing the total from active, front, sync and back widths.
- Sub-module vga_axis_counter holds one wrapping counter with an enable, a wrap output, and a sync-window decode.
  - One instance is for columns, enabled by i_Pix_En.
  - One instance is for rows, enabled by i_Pix_En AND the column wrap.

## Test plan
- Defaults, reset released, 800 enabled cycles -> o_HSync low for exactly cols 656–751 (96 cycles); o_Line_Start high only at col 0; o_Active high for cols 0–639.
- Defaults, 420000 enabled cycles -> exactly one o_Frame_Start; o_VSync low only on rows 490–491; o_Active high for 307200 cycles total.
- i_Pix_En held low for 5 cycles at col 100, row 7 -> counts and all outputs unchanged; col becomes 101 on the next enabled edge.
- Reset pulsed between clock edges at col 400, row 300 -> counts read 0 before the next edge; the next frame starts at (0,0).
- 800x600 parameters with HSYNC_POL = VSYNC_POL = 1 -> o_HSync high for cols 840–967; o_VSync high for rows 601–604; line length 1056; frame length 628 lines.
- VGA_TIMING_REG_OUT_EN defined -> every output equals the default build's output delayed by one enabled cycle; first post-reset outputs are inactive with o_Active = 0.
